// File: rtl/fir_inverse.sv
// fir_inverse: streaming deconvolution of a 4-tap FIR using one shared multiplier
module fir_inverse #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 3
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [COEF_W-1:0] B0,
  input  logic [COEF_W-1:0] B1,
  input  logic [COEF_W-1:0] B2,
  input  logic [COEF_W-1:0] B3,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Dout,
  output logic              coef_err
);
  typedef enum logic [2:0] {IDLE, MAC2, MAC1, MAC0, SCALE, OUT} state_t;
  function automatic int nit();
    int k;
    k = 0;
    while ((3 << k) < DATA_W) k++;
    return k;
  endfunction
  localparam int NIT = nit();
  localparam logic [DATA_W-1:0] TWO = DATA_W'(2);
  // b*b == 1 mod 8 for odd b, and each Newton step doubles the correct bits
  function automatic logic [DATA_W-1:0] inv(input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] v;
    v = b;
    for (int i = 0; i < NIT; i++) v = v * (TWO - b * v);
    return v;
  endfunction
  state_t state, state_nx;
  logic [DATA_W-1:0] acc, h1, h2, h3, ma, mb, prod, x;
  logic [COEF_W-1:0] b0s, b1s, b2s, b3s;
  assign in_ready  = state == IDLE;
  assign out_valid = state == OUT;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? MAC2 : IDLE;
      MAC2:    state_nx = MAC1;
      MAC1:    state_nx = MAC0;
      MAC0:    state_nx = SCALE;
      SCALE:   state_nx = OUT;
      OUT:     state_nx = out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  // the single multiplier serves the three feedback taps and the final scale
  always_comb begin
    ma = state == MAC2 ? DATA_W'(b2s) : state == MAC1 ? DATA_W'(b1s) :
         state == MAC0 ? DATA_W'(b0s) : inv(DATA_W'(b3s));
    mb = state == MAC2 ? h1 : state == MAC1 ? h2 : state == MAC0 ? h3 : acc;
    prod = ma * mb;
    x = b3s[0] ? prod : '0;
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      h1       <= '0;
      h2       <= '0;
      h3       <= '0;
      b0s      <= '0;
      b1s      <= '0;
      b2s      <= '0;
      b3s      <= '0;
      Dout     <= '0;
      coef_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        acc <= Din;
        b0s <= B0;
        b1s <= B1;
        b2s <= B2;
        b3s <= B3;
      end
      if (state == MAC2 || state == MAC1 || state == MAC0) acc <= acc - prod;
      if (state == SCALE) begin
        Dout <= x;
        h3   <= h2;
        h2   <= h1;
        h1   <= x;
        if (!b3s[0]) coef_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_inverse.sv
// tb_fir_inverse: directed self-checking bench for fir_inverse
module tb_fir_inverse;
  logic       CLK = 0;
  logic       reset = 1;
  logic [2:0] B0 = 0, B1 = 0, B2 = 0, B3 = 1;
  logic       in_valid = 0, out_ready = 1;
  logic [7:0] Din = 0;
  logic       in_ready, out_valid, coef_err;
  logic [7:0] Dout;
  int checks = 0, failures = 0;

  fir_inverse #(.DATA_W(8), .COEF_W(3)) dut (
    .CLK(CLK), .reset(reset), .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .in_valid(in_valid), .in_ready(in_ready), .Din(Din),
    .out_valid(out_valid), .out_ready(out_ready), .Dout(Dout), .coef_err(coef_err)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    reset = 1;
    in_valid = 0;
    out_ready = 1;
    @(negedge CLK);
    @(negedge CLK);
    reset = 0;
  endtask

  task automatic send(input logic [7:0] y, input logic [2:0] c0, c1, c2, c3,
                      output logic [7:0] x, output int lat);
    int n;
    @(negedge CLK);
    B0 = c0; B1 = c1; B2 = c2; B3 = c3;
    Din = y;
    in_valid = 1;
    out_ready = 1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    #1 in_valid = 0;
    B0 = ~c0; B1 = ~c1; B2 = ~c2; B3 = ~c3;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge CLK);
      lat++;
      #1;
    end
    x = Dout;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (Dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", Dout); end
    if (coef_err !== 1'b0) begin failures++; $display("FAIL reset_coef_err got=%b exp=0", coef_err); end
  endtask

  task automatic test_identity();
    logic [7:0] ys[3] = '{8'h5A, 8'hFF, 8'h00};
    logic [7:0] x;
    int lat;
    for (int i = 0; i < 3; i++) begin
      send(ys[i], 0, 0, 0, 1, x, lat);
      checks += 2;
      if (x !== ys[i]) begin failures++; $display("FAIL identity_dout[%0d] got=%h exp=%h", i, x, ys[i]); end
      if (lat !== 4) begin failures++; $display("FAIL identity_latency[%0d] got=%0d exp=4", i, lat); end
    end
    checks++;
    if (coef_err !== 1'b0) begin failures++; $display("FAIL identity_coef_err got=%b exp=0", coef_err); end
  endtask

  task automatic test_scale();
    logic [7:0] x;
    int lat;
    send(8'd3, 0, 0, 0, 3, x, lat);
    checks++;
    if (x !== 8'd1) begin failures++; $display("FAIL scale3_y3 got=%0d exp=1", x); end
    send(8'd255, 0, 0, 0, 3, x, lat);
    checks++;
    if (x !== 8'd85) begin failures++; $display("FAIL scale3_y255 got=%0d exp=85", x); end
    send(8'd7, 0, 0, 0, 7, x, lat);
    checks++;
    if (x !== 8'd1) begin failures++; $display("FAIL scale7_y7 got=%0d exp=1", x); end
    send(8'd1, 0, 0, 0, 5, x, lat);
    checks++;
    if (x !== 8'd205) begin failures++; $display("FAIL scale5_y1 got=%0d exp=205", x); end
  endtask

  task automatic test_feedback();
    logic [7:0] x;
    int lat;
    do_reset();
    send(8'd5, 0, 0, 1, 1, x, lat);
    checks++;
    if (x !== 8'd5) begin failures++; $display("FAIL feedback_first got=%0d exp=5", x); end
    send(8'd7, 0, 0, 1, 1, x, lat);
    checks++;
    if (x !== 8'd2) begin failures++; $display("FAIL feedback_second got=%0d exp=2", x); end
    send(8'd9, 1, 1, 1, 1, x, lat);
    checks++;
    if (x !== 8'd2) begin failures++; $display("FAIL feedback_third got=%0d exp=2", x); end
  endtask

  task automatic test_roundtrip();
    logic [7:0] xo, p1, p2, p3, y, x;
    int lat;
    do_reset();
    p1 = 0; p2 = 0; p3 = 0;
    for (int i = 0; i < 64; i++) begin
      xo = 8'($urandom);
      y = 8'(3 * xo + 7 * p1 + 2 * p2 + 5 * p3);
      p3 = p2; p2 = p1; p1 = xo;
      send(y, 5, 2, 7, 3, x, lat);
      checks++;
      if (x !== xo) begin failures++; $display("FAIL roundtrip[%0d] got=%h exp=%h", i, x, xo); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge CLK);
    out_ready = 1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    B0 = 0; B1 = 0; B2 = 0; B3 = 1;
    Din = 8'hC3;
    in_valid = 1;
    out_ready = 0;
    @(posedge CLK);
    #1 Din = 8'h3C;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge CLK);
      n++;
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks += 3;
      if (Dout !== 8'hC3) begin failures++; $display("FAIL bp_hold_dout[%0d] got=%h exp=c3", i, Dout); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
    end
    out_ready = 1;
    @(posedge CLK);
    @(posedge CLK);
    #1 in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge CLK);
      n++;
      #1;
    end
    checks += 2;
    if (Dout !== 8'h3C) begin failures++; $display("FAIL bp_waiting_sample got=%h exp=3c", Dout); end
    if (n !== 4) begin failures++; $display("FAIL bp_waiting_latency got=%0d exp=4", n); end
  endtask

  task automatic test_bad_coef();
    logic [7:0] x;
    int lat;
    send(8'h37, 0, 0, 0, 2, x, lat);
    checks += 2;
    if (x !== 8'h00) begin failures++; $display("FAIL badcoef_dout got=%h exp=00", x); end
    if (coef_err !== 1'b1) begin failures++; $display("FAIL badcoef_flag got=%b exp=1", coef_err); end
    send(8'h11, 0, 0, 0, 1, x, lat);
    checks += 2;
    if (x !== 8'h11) begin failures++; $display("FAIL badcoef_recover got=%h exp=11", x); end
    if (coef_err !== 1'b1) begin failures++; $display("FAIL badcoef_sticky got=%b exp=1", coef_err); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] x;
    int lat, n;
    @(negedge CLK);
    out_ready = 1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    B0 = 1; B1 = 1; B2 = 1; B3 = 1;
    Din = 8'h20;
    in_valid = 1;
    @(posedge CLK);
    #1 in_valid = 0;
    @(posedge CLK);
    #1 reset = 1;
    @(posedge CLK);
    #1 reset = 0;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
    if (Dout !== 8'h00) begin failures++; $display("FAIL midreset_dout got=%h exp=00", Dout); end
    if (coef_err !== 1'b0) begin failures++; $display("FAIL midreset_coef_err got=%b exp=0", coef_err); end
    send(8'd4, 1, 1, 1, 1, x, lat);
    checks += 2;
    if (x !== 8'd4) begin failures++; $display("FAIL midreset_next got=%0d exp=4", x); end
    if (lat !== 4) begin failures++; $display("FAIL midreset_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_scale();
    test_feedback();
    test_roundtrip();
    test_backpressure();
    test_bad_coef();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
